dcsk_rx_correlator: RTL
=======================

# dcsk_rx_correlator

Receive-side DCSK despreader: the counterpart of the transmit serializer's chip counter. Takes a stream of signed chip samples for each bit period, stores the reference half, correlates the data half against it, and decides one bit per period. Decided bits are packed MSB-first into words for the downstream byte sink. Frame start and spreading factor come from the receiver control block.

## Interface
- `CHIP_W`, default 8: signed chip sample width.
- `OUT_W`, default 8: bits per output word.
- `FRAME_BITS`, default 32: bits per frame. Must be a multiple of `OUT_W`, enforced by an elaboration-time assertion.

Ports:
- `i_clk`  in  1  the single clock.
- `i_arst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  one-cycle frame start pulse; latches `i_spreading_factor`.
- `i_spreading_factor`  in  2  SF code from `spreading_factors_pkg`: SF2, SF4, SF8, SF16.
- `i_chip_valid`  in  1  `i_chip` holds a valid sample this cycle.
- `i_chip`  in  CHIP_W  signed chip sample.
- `o_busy`  out  1  frame in progress.
- `o_chip_index`  out  5  chip position within the current bit period.
- `o_msb`  out  1  high during the data half, low during the reference half.
- `o_bit`  out  1  decided bit.
- `o_bit_valid`  out  1  one-cycle strobe qualifying `o_bit`.
- `o_word`  out  OUT_W  assembled word, MSB = first decided bit.
- `o_word_valid`  out  1  one-cycle strobe qualifying `o_word`.
- `o_corr`  out  2*CHIP_W+4  signed correlation of the last decided bit, for debug.

## Operation
- Half length `H` is 2, 4, 8 or 16 chips for SF2, SF4, SF8 and SF16. One bit period is 2H chips.
- The SF is latched at `i_start` and held for the whole frame. Changes on the input mid-frame are ignored.
- States:
  - IDLE: waits for `i_start`, then goes to REF.
  - REF: captures chip k of the period into `ref_buf[k]`, for k = 0..H-1. After chip H-1 is accepted, goes to DATA.
  - DATA: for chip k = H..2H-1, adds `i_chip * ref_buf[k-H]` (full-precision signed product) into the accumulator. The accumulator is cleared at the start of DATA. After chip 2H-1 is accepted, goes to DECIDE.
  - DECIDE: one cycle.
    - Sets `o_bit = (acc >= 0)`, so a tie decides 1. Pulses `o_bit_valid`, loads `o_corr`, and shifts the bit into the word register.
    - If the bit count reaches `FRAME_BITS`, goes to IDLE; otherwise goes to REF.
- Only cycles with `i_chip_valid` high advance `o_chip_index`. Idle cycles inside REF or DATA hold all state.
- Any chip arriving during DECIDE or IDLE is dropped. The upstream source guarantees a gap of at least one cycle between periods.
- A chip presented in the same cycle as `i_start` is ignored; chip 0 is the first valid chip after `i_start`.
- `o_msb` is 0 in REF and 1 in DATA.
- The accumulator is 2*CHIP_W+4 bits wide and sign-extended. Sixteen products cannot overflow it.
- Word assembly:
  - Each decided bit is shifted into the LSB of the word register, so the first bit ends up in the MSB.
  - After the OUT_W-th bit, `o_word` updates and `o_word_valid` pulses in the same cycle as `o_bit_valid`.
- `i_start` while busy aborts the frame: counters, accumulator, partial word and bit count are cleared, the new SF is latched, and the FSM enters REF. No strobe is issued for the aborted partial word.

## Timing
- Reset values: all outputs are 0, and the FSM is in IDLE.
- `o_busy` rises the cycle after `i_start` and falls the cycle after the final DECIDE.
- Decision latency: `o_bit_valid` and `o_bit` appear exactly one cycle after the cycle in which chip 2H-1 is accepted.
- `o_bit`, `o_word` and `o_corr` hold their values until the next strobe.
- `o_chip_index` is registered:
  - It equals the index of the next chip to be accepted.
  - It wraps from 2H-1 to 0 on entry to DECIDE.
  - It resets to 0 on `i_start`.
- Reset asserted mid-frame returns every register to its reset value immediately. No strobe is issued.

## Structure
- Shared package `spreading_factors_pkg` gains:
  - function `sf_half_len(sf)`, returning 2, 4, 8 or 16;
  - enum `dcsk_rx_state_e` with values IDLE, REF, DATA, DECIDE.
- Sub-module `dcsk_rx_chip_ctr`:
  - inputs: valid-gated chip counter, latched SF, clear;
  - outputs: `o_chip_index`, `o_msb`, and a last-chip flag.
- The reference buffer (16 × CHIP_W), MAC, FSM and word packer live in the top level.

## Test plan
- SF2, ref chips 10, -20, data chips 10, -20 -> `o_corr` = 500, `o_bit` = 1, one cycle after the last chip.
- SF2, ref chips 10, -20, data chips -10, 20 -> `o_corr` = -500, `o_bit` = 0. SF16 with all chips 127 / -128 (same sign) -> `o_corr` = 258064, no overflow.
- SF4, 8 bits encoding 0xA5 with `i_chip_valid` toggling every other cycle -> `o_word` = 0xA5, `o_word_valid` pulses once, coinciding with the 8th `o_bit_valid`.
- FRAME_BITS = 32 -> exactly four `o_word_valid` pulses, then `o_busy` falls. An SF change mid-frame has no effect.
- `i_start` re-asserted after 3 bits -> no word strobe; the next 8 bits form a fresh word.
- `i_arst` pulsed mid-DATA -> all outputs 0, IDLE; the next `i_start` decodes correctly. Zero correlation (data all 0) -> `o_bit` = 1.

Source files
------------

// File: rtl/dcsk_rx_correlator_pkg.sv
// Spreading-factor codes and DCSK receiver state encoding shared by the
// transmit and receive sides.
package spreading_factors_pkg;

    typedef enum logic [1:0] {
        SF2  = 2'd0,
        SF4  = 2'd1,
        SF8  = 2'd2,
        SF16 = 2'd3
    } sf_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REF    = 2'd1,
        DATA   = 2'd2,
        DECIDE = 2'd3
    } dcsk_rx_state_e;

    // Chips per half bit period: 2, 4, 8 or 16.
    function automatic logic [4:0] sf_half_len(input logic [1:0] sf);
        return 5'd2 << sf;
    endfunction

endpackage

// File: rtl/dcsk_rx_correlator_if.sv
// Chip-stream input and decision/word outputs of the DCSK despreader.
interface dcsk_rx_if #(
    parameter int CHIP_W = 8,
    parameter int OUT_W  = 8
);
    logic                  i_start;
    logic [1:0]            i_spreading_factor;
    logic                  i_chip_valid;
    logic [CHIP_W-1:0]     i_chip;
    logic                  o_busy;
    logic [4:0]            o_chip_index;
    logic                  o_msb;
    logic                  o_bit;
    logic                  o_bit_valid;
    logic [OUT_W-1:0]      o_word;
    logic                  o_word_valid;
    logic [2*CHIP_W+3:0]   o_corr;

    // Receiver control / chip source side.
    modport master (
        output i_start, i_spreading_factor, i_chip_valid, i_chip,
        input  o_busy, o_chip_index, o_msb, o_bit, o_bit_valid,
               o_word, o_word_valid, o_corr
    );

    // Despreader side.
    modport slave (
        input  i_start, i_spreading_factor, i_chip_valid, i_chip,
        output o_busy, o_chip_index, o_msb, o_bit, o_bit_valid,
               o_word, o_word_valid, o_corr
    );
endinterface

// File: rtl/dcsk_rx_correlator_chip_ctr.sv
// Chip position counter within one bit period (2H chips); flags the data
// half and the last chip of the period.
module dcsk_rx_chip_ctr
    import spreading_factors_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic       i_clear,
    input  logic       i_adv,
    input  logic [1:0] i_sf,
    output logic [4:0] o_chip_index,
    output logic       o_msb,
    output logic       o_last
);
    logic [4:0] half;
    logic [3:0] hm1;
    logic [4:0] idx_q, idx_d;

    assign half = sf_half_len(i_sf);
    assign hm1  = 4'(half - 5'd1);

    assign o_chip_index = idx_q;
    assign o_msb        = (idx_q >= half);
    // 2H-1 is H-1 shifted left with a one filled in (H is a power of two).
    assign o_last       = (idx_q == {hm1, 1'b1});

    // Next index: clear wins, otherwise advance only on accepted chips.
    always_comb begin
        idx_d = idx_q;
        if (i_clear)
            idx_d = '0;
        else if (i_adv)
            idx_d = o_last ? 5'd0 : idx_q + 5'd1;
    end

    // Index register.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) idx_q <= '0;
        else        idx_q <= idx_d;
    end
endmodule

// File: rtl/dcsk_rx_correlator.sv
// DCSK receive despreader: stores the reference half of each bit period,
// correlates the data half against it, decides one bit per period and packs
// decided bits MSB-first into output words.
module dcsk_rx_correlator
    import spreading_factors_pkg::*;
#(
    parameter int CHIP_W     = 8,
    parameter int OUT_W      = 8,
    parameter int FRAME_BITS = 32
) (
    input  logic    i_clk,
    input  logic    i_arst,
    dcsk_rx_if.slave bus
);
    localparam int ACC_W  = 2*CHIP_W + 4;
    localparam int WCNT_W = $clog2(OUT_W);
    localparam int FCNT_W = $clog2(FRAME_BITS + 1);

    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_REF    = REF;
    localparam logic [1:0] S_DATA   = DATA;
    localparam logic [1:0] S_DECIDE = DECIDE;

    if ((FRAME_BITS % OUT_W) != 0) begin : g_bad_frame_bits
        $error("FRAME_BITS must be a multiple of OUT_W");
    end

    logic [1:0]               state_q, state_d;
    logic [1:0]               sf_q;
    logic [3:0]               half_lo, hm1;
    logic [4:0]               idx;
    logic                     msb, last;
    logic                     adv, ref_last, data_last;
    logic signed [CHIP_W-1:0] chip_s;
    logic signed [CHIP_W-1:0] ref_q [16];
    logic [3:0]               rd_idx;
    logic signed [2*CHIP_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q, acc_next;
    logic                     bit_d;
    logic [OUT_W-2:0]         sr_q;
    logic [OUT_W-1:0]         sr_next;
    logic [WCNT_W-1:0]        wcnt_q;
    logic [FCNT_W-1:0]        fcnt_q;
    logic                     busy_q, bit_q, bit_valid_q, word_valid_q;
    logic [OUT_W-1:0]         word_q;
    logic signed [ACC_W-1:0]  corr_q;

    assign half_lo = 4'(sf_half_len(sf_q));
    assign hm1     = half_lo - 4'd1;
    assign chip_s  = bus.i_chip;

    // A chip coinciding with i_start belongs to no period and is dropped.
    assign adv       = bus.i_chip_valid && !bus.i_start &&
                       (state_q == S_REF || state_q == S_DATA);
    assign ref_last  = adv && (state_q == S_REF) && (idx[3:0] == hm1);
    assign data_last = adv && (state_q == S_DATA) && last;

    dcsk_rx_chip_ctr u_ctr (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_clear      (bus.i_start),
        .i_adv        (adv),
        .i_sf         (sf_q),
        .o_chip_index (idx),
        .o_msb        (msb),
        .o_last       (last)
    );

    // MAC datapath; 4-bit wrap of idx-H is exact since idx < 2H <= 32.
    always_comb begin
        rd_idx   = idx[3:0] - half_lo;
        prod     = chip_s * ref_q[rd_idx];
        acc_next = acc_q + {{4{prod[2*CHIP_W-1]}}, prod};
        bit_d    = ~acc_next[ACC_W-1];
        sr_next  = {sr_q, bit_d};
    end

    // Next-state logic; i_start always (re)enters REF.
    always_comb begin
        state_d = state_q;
        if (bus.i_start) begin
            state_d = S_REF;
        end else begin
            case (state_q)
                S_REF:    if (ref_last)  state_d = S_DATA;
                S_DATA:   if (data_last) state_d = S_DECIDE;
                S_DECIDE: state_d = (fcnt_q == FCNT_W'(FRAME_BITS)) ? S_IDLE : S_REF;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // State and latched spreading factor.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_IDLE;
            sf_q    <= '0;
        end else begin
            state_q <= state_d;
            if (bus.i_start) sf_q <= bus.i_spreading_factor;
        end
    end

    // Reference half capture.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int i = 0; i < 16; i++) ref_q[i] <= '0;
        end else if (adv && state_q == S_REF) begin
            ref_q[idx[3:0]] <= chip_s;
        end
    end

    // Accumulator: cleared on entry to DATA, accumulates data-half products.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst)
            acc_q <= '0;
        else if (bus.i_start || ref_last)
            acc_q <= '0;
        else if (adv && state_q == S_DATA)
            acc_q <= acc_next;
    end

    // Decision is registered off the final product, so strobes are visible
    // during DECIDE, one cycle after the last chip.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            busy_q       <= 1'b0;
            bit_q        <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            corr_q       <= '0;
            sr_q         <= '0;
            wcnt_q       <= '0;
            fcnt_q       <= '0;
        end else begin
            bit_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
            if (bus.i_start) begin
                busy_q <= 1'b1;
                sr_q   <= '0;
                wcnt_q <= '0;
                fcnt_q <= '0;
            end else if (data_last) begin
                bit_q       <= bit_d;
                bit_valid_q <= 1'b1;
                corr_q      <= acc_next;
                sr_q        <= sr_next[OUT_W-2:0];
                fcnt_q      <= fcnt_q + 1'b1;
                if (wcnt_q == WCNT_W'(OUT_W-1)) begin
                    word_q       <= sr_next;
                    word_valid_q <= 1'b1;
                    wcnt_q       <= '0;
                end else begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end else if (state_q == S_DECIDE && state_d == S_IDLE) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign bus.o_busy       = busy_q;
    assign bus.o_chip_index = idx;
    assign bus.o_msb        = msb;
    assign bus.o_bit        = bit_q;
    assign bus.o_bit_valid  = bit_valid_q;
    assign bus.o_word       = word_q;
    assign bus.o_word_valid = word_valid_q;
    assign bus.o_corr       = corr_q;
endmodule
